// File: rtl/shift_feeder_pkg.sv
// Shared definitions for shift_feeder: default word width, FSM encoding, clog2 helper.
package shift_feeder_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_feeder_if.sv
// Upstream valid/ready word handshake into shift_feeder.
interface shift_feeder_if
    import shift_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/shift_feeder_sync_fifo.sv
// sync_fifo: WIDTH x DEPTH word buffer with synchronous clear, head-register read.
module sync_fifo
    import shift_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [clog2(DEPTH):0]   level
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    // Pointer and occupancy update; simultaneous push/pop leaves level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state; clear flushes the buffer by rewinding pointers.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/shift_feeder.sv
// shift_feeder: queues parallel words and sequences load/enable for shift_out.
// Optional SHIFT_FEEDER_GAP_EN adds GAP idle cycles after every word.
module shift_feeder
    import shift_feeder_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CWIDTH = 3,
    parameter int unsigned GAP    = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    shift_feeder_if.slave         in_if,
    output logic [WIDTH-1:0]      data_in,
    output logic                  load,
    output logic                  enable,
    output logic                  busy,
    output logic [clog2(DEPTH):0] level
);
    localparam int unsigned LW = clog2(DEPTH) + 1;

    // Elaboration-time parameter sanity.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("shift_feeder: DEPTH must be a power of two >= 2");
    end
    if ((64'd1 << CWIDTH) < 64'(WIDTH)) begin : g_bad_cwidth
        $error("shift_feeder: CWIDTH too small for WIDTH");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("shift_feeder: GAP must be >= 1");
    end

    logic [WIDTH-1:0]  head_c;
    logic              push_c;
    logic              pop_c;
    logic              start_c;
    logic              nempty_c;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_in_q, data_in_d;
    logic              load_q, load_d;
    logic              enable_q, enable_d;
    logic              busy_q, busy_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
`ifdef SHIFT_FEEDER_GAP_EN
    localparam int unsigned GW = clog2(GAP + 1);
    logic [GW-1:0]     gcnt_q, gcnt_d;
`endif

    // Ready only while not full, from the registered level (no full-bypass).
    assign in_if.in_ready = (level < LW'(DEPTH));
    assign push_c         = in_if.in_valid & in_if.in_ready;
    assign nempty_c       = (level != '0);

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (in_if.in_data),
        .rdata (head_c),
        .level (level)
    );

    // Next-state and registered-output logic; entering LOAD pops the head word.
    always_comb begin
        state_d   = state_q;
        data_in_d = data_in_q;
        load_d    = 1'b0;
        enable_d  = 1'b0;
        cnt_d     = cnt_q;
        start_c   = 1'b0;
        pop_c     = 1'b0;
`ifdef SHIFT_FEEDER_GAP_EN
        gcnt_d    = gcnt_q;
`endif
        case (state_q)
            ST_IDLE: start_c = nempty_c;
            ST_LOAD: begin
                state_d  = ST_SHIFT;
                enable_d = 1'b1;
                cnt_d    = '0;
            end
            ST_SHIFT: begin
                if (cnt_q == CWIDTH'(WIDTH - 1)) begin
`ifdef SHIFT_FEEDER_GAP_EN
                    state_d = ST_GAP;
                    gcnt_d  = '0;
`else
                    state_d = ST_IDLE;
                    start_c = nempty_c;
`endif
                end else begin
                    enable_d = 1'b1;
                    cnt_d    = cnt_q + CWIDTH'(1);
                end
            end
`ifdef SHIFT_FEEDER_GAP_EN
            ST_GAP: begin
                if (gcnt_q == GW'(GAP - 1)) begin
                    state_d = ST_IDLE;
                    start_c = nempty_c;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (start_c) begin
            state_d   = ST_LOAD;
            load_d    = 1'b1;
            data_in_d = head_c;
            pop_c     = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; clear aborts any word in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            data_in_q <= '0;
            load_q    <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef SHIFT_FEEDER_GAP_EN
            gcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            data_in_q <= data_in_d;
            load_q    <= load_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
`ifdef SHIFT_FEEDER_GAP_EN
            gcnt_q    <= gcnt_d;
`endif
        end
    end

    assign data_in = data_in_q;
    assign load    = load_q;
    assign enable  = enable_q;
    assign busy    = busy_q;

endmodule
